alu_exec_unit: RTL and testbench

- Parametrised successor to the pipeline's combinational ALU control decode.
- Merges funct/ALUOp decode with a registered execute stage.
- Single-cycle path for logic/add/sub/slt; iterative multi-cycle path for multiply, with a valid/ready handshake.
- Sits in the EX stage. busy_o drives the hazard unit's stall.

---
 rtl/alu_exec_unit.sv | 185 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with funct/ALUOp decode and a registered result.
// Logic, add, sub and slt results come out one cycle after accept. Multiply
// uses an iterative shift-add datapath that retires MUL_BITS multiplier bits
// per cycle and holds off new requests (ready_o=0, busy_o=1) until it is done.
// Optional feature macro: ALU_MULH_EN adds mulh (funct 011001, code 7), which
// returns the upper WIDTH bits of the unsigned product. With the macro
// enabled the accumulator is 2*WIDTH bits wide.
//
// state  | meaning
// S_IDLE | ready for a request; non-mul ops finish here in one cycle
// S_MUL  | iterating the multiply; requests are held off until done
module alu_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [5:0]       funct_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic [2:0]       ALUCtrl_o,
    output logic             busy_o
);

    localparam int MUL_ITER = WIDTH / MUL_BITS;
    localparam int CNT_W    = $clog2(MUL_ITER + 1);
`ifdef ALU_MULH_EN
    localparam int ACC_W    = 2 * WIDTH;
`else
    localparam int ACC_W    = WIDTH;
`endif

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               zero_q, zero_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2:0]         ctrl_dec;
    logic               iter_dec;
    logic [WIDTH-1:0]   alu_res;
    logic [ACC_W-1:0]   acc_sum;
    logic [WIDTH-1:0]   mul_res;

    // ALUOp overrides funct; only R-type looks at the funct field
    always_comb begin
        ctrl_dec = 3'd0;
        case (ALUOp_i)
            2'd1:    ctrl_dec = 3'd1;
            2'd2:    ctrl_dec = 3'd2;
            2'd3:    ctrl_dec = 3'd0;
            default: begin
                case (funct_i)
                    6'b100000: ctrl_dec = 3'd1;
                    6'b100010: ctrl_dec = 3'd2;
                    6'b100100: ctrl_dec = 3'd3;
                    6'b100101: ctrl_dec = 3'd4;
                    6'b011000: ctrl_dec = 3'd5;
                    6'b101010: ctrl_dec = 3'd6;
`ifdef ALU_MULH_EN
                    6'b011001: ctrl_dec = 3'd7;
`endif
                    default:   ctrl_dec = 3'd0;
                endcase
            end
        endcase
    end

`ifdef ALU_MULH_EN
    assign iter_dec = (ctrl_dec == 3'd5) || (ctrl_dec == 3'd7);
`else
    assign iter_dec = (ctrl_dec == 3'd5);
`endif

    // Single-cycle result for the non-iterative codes
    always_comb begin
        alu_res = '0;
        case (ctrl_dec)
            3'd1:    alu_res = data1_i + data2_i;
            3'd2:    alu_res = data1_i - data2_i;
            3'd3:    alu_res = data1_i & data2_i;
            3'd4:    alu_res = data1_i | data2_i;
            3'd6:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            default: alu_res = '0;
        endcase
    end

    // The multiplicand is pre-shifted each step, so the partial product adds in place
    assign acc_sum = acc_q + (mcand_q * ACC_W'(mplier_q[MUL_BITS-1:0]));

`ifdef ALU_MULH_EN
    assign mul_res = (ctrl_q == 3'd7) ? acc_sum[ACC_W-1 -: WIDTH] : acc_sum[WIDTH-1:0];
`else
    assign mul_res = acc_sum;
`endif

    // Next-state and datapath updates; every _d defaults to hold
    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        zero_d   = zero_q;
        ctrl_d   = ctrl_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    ctrl_d = ctrl_dec;
                    if (iter_dec) begin
                        mcand_d  = ACC_W'(data1_i);
                        mplier_d = data2_i;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(MUL_ITER);
                        state_d  = S_MUL;
                    end else begin
                        data_d  = alu_res;
                        zero_d  = (alu_res == '0);
                        valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << MUL_BITS;
                mplier_d = mplier_q >> MUL_BITS;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    data_d  = mul_res;
                    zero_d  = (mul_res == '0);
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight multiply
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            zero_q   <= 1'b0;
            ctrl_q   <= 3'd0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            ctrl_q   <= ctrl_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign busy_o    = (state_q != S_IDLE);
    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign zero_o    = zero_q;
    assign ALUCtrl_o = ctrl_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit (WIDTH=32, MUL_BITS=1). A cycle-level reference
// model computes each result with plain arithmetic at accept time and
// publishes it after the op's latency; a negedge process compares every
// output against it every cycle. Directed vectors add literal checks.
module tb_alu_exec_unit;

    localparam int WIDTH    = 32;
    localparam int MUL_BITS = 1;
    localparam int MUL_ITER = WIDTH / MUL_BITS;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_i = 1'b0;
    logic [5:0]       funct_i = '0;
    logic [1:0]       ALUOp_i = '0;
    logic [WIDTH-1:0] data1_i = '0;
    logic [WIDTH-1:0] data2_i = '0;
    logic             ready_o, valid_o, zero_o, busy_o;
    logic [WIDTH-1:0] data_o;
    logic [2:0]       ALUCtrl_o;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit #(.WIDTH(WIDTH), .MUL_BITS(MUL_BITS)) u_dut (
        .clk_i(clk_i), .rst_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .funct_i(funct_i), .ALUOp_i(ALUOp_i), .data1_i(data1_i), .data2_i(data2_i),
        .valid_o(valid_o), .data_o(data_o), .zero_o(zero_o),
        .ALUCtrl_o(ALUCtrl_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd1) return 3'd1;
        if (op == 2'd2) return 3'd2;
        if (op == 2'd3) return 3'd0;
        if (f == 6'b100000) return 3'd1;
        if (f == 6'b100010) return 3'd2;
        if (f == 6'b100100) return 3'd3;
        if (f == 6'b100101) return 3'd4;
        if (f == 6'b011000) return 3'd5;
        if (f == 6'b101010) return 3'd6;
`ifdef ALU_MULH_EN
        if (f == 6'b011001) return 3'd7;
`endif
        return 3'd0;
    endfunction

    function automatic logic [WIDTH-1:0] ref_calc(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (c)
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return p[WIDTH-1:0];
            3'd6: return ($signed(a) < $signed(b)) ? 1 : 0;
            3'd7: return p[2*WIDTH-1:WIDTH];
            default: return '0;
        endcase
    endfunction

    // Reference model: results computed at accept, published after latency
    logic [2:0]       m_code;
    logic [WIDTH-1:0] m_res;
    assign m_code = ref_decode(ALUOp_i, funct_i);
    assign m_res  = ref_calc(m_code, data1_i, data2_i);

    int               cyc = 0;
    int               m_done_at = 0;
    logic             m_busy = 1'b0;
    logic             m_valid = 1'b0;
    logic             m_zero = 1'b0;
    logic [2:0]       m_ctrl = '0;
    logic [WIDTH-1:0] m_data = '0;
    logic [WIDTH-1:0] m_pend = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_zero  <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy) begin
                if (cyc == m_done_at) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_data  <= m_pend;
                    m_zero  <= (m_pend == '0);
                end
            end else if (valid_i) begin
                m_ctrl <= m_code;
                if (m_code == 3'd5 || m_code == 3'd7) begin
                    m_busy    <= 1'b1;
                    m_done_at <= cyc + MUL_ITER;
                    m_pend    <= m_res;
                end else begin
                    m_valid <= 1'b1;
                    m_data  <= m_res;
                    m_zero  <= (m_res == '0);
                end
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk_i) begin
        check("valid_o", 64'(valid_o), 64'(m_valid));
        check("ready_o", 64'(ready_o), 64'(!m_busy));
        check("busy_o", 64'(busy_o), 64'(m_busy));
        check("data_o", 64'(data_o), 64'(m_data));
        check("zero_o", 64'(zero_o), 64'(m_zero));
        check("ALUCtrl_o", 64'(ALUCtrl_o), 64'(m_ctrl));
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [5:0] f,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        ALUOp_i = op;
        funct_i = f;
        data1_i = a;
        data2_i = b;
    endtask

    // One request held for exactly one accepting edge
    task automatic drive(input logic [1:0] op, input logic [5:0] f,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        set_op(op, f, a, b);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready_o && t < 200) begin
            step();
            t++;
        end
        if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
    } opsel_t;

    opsel_t tbl[8];

    initial begin
        int busy_cnt;
        int first_v;
        int v_cnt;

        tbl[0] = '{2'd0, 6'b100000};
        tbl[1] = '{2'd0, 6'b100010};
        tbl[2] = '{2'd0, 6'b100100};
        tbl[3] = '{2'd0, 6'b100101};
        tbl[4] = '{2'd0, 6'b011000};
        tbl[5] = '{2'd0, 6'b101010};
        tbl[6] = '{2'd2, 6'b000000};
        tbl[7] = '{2'd3, 6'b100000};

        rst_n = 1'b0;
        repeat (3) step();
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        rst_n = 1'b1;
        step();

        // add 7+5, one-cycle pulse
        drive(2'd0, 6'b100000, 32'd7, 32'd5);
        check("add_valid", 64'(valid_o), 64'd1);
        check("add_data", 64'(data_o), 64'd12);
        check("add_ctrl", 64'(ALUCtrl_o), 64'd1);
        check("add_zero", 64'(zero_o), 64'd0);
        step();
        check("add_valid_drop", 64'(valid_o), 64'd0);
        check("add_hold", 64'(data_o), 64'd12);

        // back-to-back sub, or, slt
        set_op(2'd0, 6'b100010, 32'd5, 32'd5);
        valid_i = 1'b1;
        step();
        check("b2b_sub_data", 64'(data_o), 64'd0);
        check("b2b_sub_zero", 64'(zero_o), 64'd1);
        set_op(2'd0, 6'b100101, 32'h0000_00F0, 32'h0000_000F);
        step();
        check("b2b_or_valid", 64'(valid_o), 64'd1);
        check("b2b_or_data", 64'(data_o), 64'hFF);
        set_op(2'd0, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        step();
        valid_i = 1'b0;
        check("b2b_slt_valid", 64'(valid_o), 64'd1);
        check("b2b_slt_data", 64'(data_o), 64'd1);

        // ALUOp=1 forces add regardless of funct
        drive(2'd1, 6'b100010, 32'd3, 32'd4);
        check("iadd_data", 64'(data_o), 64'd7);
        check("iadd_ctrl", 64'(ALUCtrl_o), 64'd1);
        drive(2'd0, 6'b111111, 32'd9, 32'd9);
        check("bad_funct_valid", 64'(valid_o), 64'd1);
        check("bad_funct_data", 64'(data_o), 64'd0);
        check("bad_funct_ctrl", 64'(ALUCtrl_o), 64'd0);
        drive(2'd0, 6'b101010, 32'd5, 32'hFFFF_FFFE);
        check("slt_signed", 64'(data_o), 64'd0);
        drive(2'd0, 6'b100000, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap_data", 64'(data_o), 64'd0);
        check("add_wrap_zero", 64'(zero_o), 64'd1);
        step();

        // mul 0x10000 * 0x10001 with a stray request held during busy
        drive(2'd0, 6'b011000, 32'h0001_0000, 32'h0001_0001);
        busy_cnt = busy_o ? 1 : 0;
        first_v  = -1;
        check("mul_ctrl_latched", 64'(ALUCtrl_o), 64'd5);
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                set_op(2'd0, 6'b100000, 32'd9, 32'd9);
                valid_i = 1'b1;
            end
            if (k == 8) valid_i = 1'b0;
            step();
            if (busy_o) busy_cnt++;
            if (valid_o && first_v < 0) begin
                first_v = k;
                check("mul_data", 64'(data_o), 64'h0001_0000);
            end
        end
        check("mul_busy_cycles", 64'(busy_cnt), 64'd32);
        check("mul_latency", 64'(first_v), 64'd32);

        drive(2'd0, 6'b011000, 32'hFFFF_FFFD, 32'd7);
        repeat (MUL_ITER) step();
        check("mul_signed_low", 64'(data_o), 64'hFFFF_FFEB);

        // reset in the middle of a multiply
        step();
        drive(2'd0, 6'b011000, 32'd3, 32'd5);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("midrst_data", 64'(data_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd1);
        check("midrst_ctrl", 64'(ALUCtrl_o), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        v_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (valid_o) v_cnt++;
        end
        check("midrst_no_valid", 64'(v_cnt), 64'd0);
        drive(2'd0, 6'b100000, 32'd1, 32'd1);
        check("post_rst_add_valid", 64'(valid_o), 64'd1);
        check("post_rst_add_data", 64'(data_o), 64'd2);
        step();

        // mulh funct 011001
        drive(2'd0, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef ALU_MULH_EN
        check("mulh_busy", 64'(busy_o), 64'd1);
        repeat (MUL_ITER) step();
        check("mulh_valid", 64'(valid_o), 64'd1);
        check("mulh_data", 64'(data_o), 64'hFFFF_FFFE);
        check("mulh_ctrl", 64'(ALUCtrl_o), 64'd7);
`else
        check("mulh_off_valid", 64'(valid_o), 64'd1);
        check("mulh_off_data", 64'(data_o), 64'd0);
        check("mulh_off_ctrl", 64'(ALUCtrl_o), 64'd0);
`endif
        step();

        // mixed directed sequence checked by the model
        for (int i = 0; i < 24; i++) begin
            wait_ready();
            drive(tbl[i % 8].op, tbl[i % 8].f, $urandom, (i % 3 == 0) ? 32'd0 : $urandom);
        end
        wait_ready();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
